// File: rtl/div_seq_ctrl_if.sv
// rtl/div_seq_ctrl_if.sv - issue/result bus between an issuing unit and the divide controller
//
// Signals:
//   start   issuer -> divider   request, honoured only while busy=0
//   a, b    issuer -> divider   binary32 dividend / divisor, captured with start
//   busy    divider -> issuer   operation in flight
//   done    divider -> issuer   one-cycle result strobe
//   result  divider -> issuer   binary32 quotient, held until the next done
//   dz      divider -> issuer   divide-by-zero flag, valid with done
interface div_seq_ctrl_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        dz;

    modport master (
        output start, a, b,
        input  busy, done, result, dz
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, dz
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - sequential binary32 divide controller with special-operand screen
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    div_seq_ctrl_if.slave (start, a, b in; busy, done, result, dz out)
//
// Special operands resolve in CHECK and go straight to OUT. Ordinary operands run
// 25 restoring-division steps (one quotient bit per cycle), then NORM forms the
// exponent, normalizes and applies overflow/underflow before OUT. Rounding is
// truncation; denormals are treated as zero.
module div_seq_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    div_seq_ctrl_if.slave     bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIV,
        S_NORM,
        S_OUT
    } state_t;

    localparam logic [31:0] NAN_OUT = 32'h7FFF_FFFF;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [24:0] r_q, r_d;
    logic [24:0] q_q, q_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        dz_q, dz_d;

    // Operand classification on the captured pair.
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic sign;
    logic [31:0] inf_out;
    logic [24:0] mb_ext;
    logic [24:0] r_sub;
    logic        r_ge;
    logic [24:0] r_after;
    logic signed [9:0] e_raw, e_adj;
    logic [22:0] frac;

    always_comb begin
        a_zero  = (a_q[30:23] == 8'd0);
        b_zero  = (b_q[30:23] == 8'd0);
        a_inf   = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf   = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan   = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan   = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        sign    = a_q[31] ^ b_q[31];
        inf_out = {sign, 31'h7F80_0000};

        // One restoring step: the remainder stays below 2*mb, so 25 bits suffice.
        mb_ext  = {2'b01, b_q[22:0]};
        r_ge    = (r_q >= mb_ext);
        r_sub   = r_q - mb_ext;
        r_after = r_ge ? r_sub : r_q;

        // Biased exponent difference; 10-bit signed covers -127..382.
        e_raw = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
        e_adj = q_q[24] ? e_raw : (e_raw - 10'sd1);
        frac  = q_q[24] ? q_q[23:1] : q_q[22:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            r_q      <= 25'd0;
            q_q      <= 25'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dz_d     = dz_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Priority order matters: NaN-producing cases first, then zero, then inf.
                state_d = S_OUT;
                dz_d    = 1'b0;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    result_d = NAN_OUT;
                end else if (a_zero || b_inf) begin
                    result_d = 32'd0;
                end else if (a_inf) begin
                    result_d = inf_out;
                end else if (b_zero) begin
                    result_d = inf_out;
                    dz_d     = 1'b1;
                end else begin
                    // Ordinary pair: leave result/dz untouched until OUT entry from NORM.
                    result_d = result_q;
                    dz_d     = dz_q;
                    r_d      = {2'b01, a_q[22:0]};
                    q_d      = 25'd0;
                    cnt_d    = 5'd0;
                    state_d  = S_DIV;
                end
            end
            S_DIV: begin
                // Quotient bits shift in MSB-first so q[24] ends up as the 2^0 bit.
                q_d   = {q_q[23:0], r_ge};
                r_d   = {r_after[23:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd24) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                dz_d    = 1'b0;
                state_d = S_OUT;
                if (e_adj >= 10'sd255) begin
                    result_d = inf_out;
                end else if (e_adj <= 10'sd0) begin
                    result_d = 32'd0;
                end else begin
                    result_d = {sign, e_adj[7:0], frac};
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_OUT);
    assign bus.result = result_q;
    assign bus.dz     = dz_q;
endmodule
